multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle control FSM for the RV32 subset datapath: add, andi, bne, sh, lh. It replaces the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back over several cycles, and adds three things:
- a `mem_ready` handshake to instruction/data memory;
- a memory-wait timeout that raises a sticky fault;
- illegal-instruction detection.

It sits between the instruction register / ALU flags and the datapath enables.

## Interface
Parameters:
- `ALU_CTRL_W`, 4, width of `alu_control`
- `MEM_TIMEOUT`, 15, maximum wait cycles with `mem_ready` low before fault; 0 disables the timeout
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  7  instr[6:0] from IR, valid from DECODE on
- `funct3`  in  3  instr[14:12] from IR
- `alu_zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes access this cycle
- `ir_write`  out  1  load IR
- `pc_write`  out  1  update PC
- `pc_src`  out  1  0 = PC+4, 1 = branch target
- `reg_write`  out  1  register file write enable
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `mem_size`  out  2  00 = word (fetch), 01 = halfword
- `alu_src_b`  out  1  0 = rs2, 1 = immediate
- `mem_to_reg`  out  1  write-back source is memory
- `alu_control`  out  ALU_CTRL_W  0000 add, 0010 and, 1111 compare
- `fault`  out  1  sticky illegal/timeout indication
- `retired`  out  CNT_W  retired-instruction count; present only with `MCU_RETIRE_COUNT_EN`

## Operation
States: RESET, FETCH, DECODE, EXEC, MEM, WB, FAULT. Outputs are Moore: a function of the state plus the latched opcode and funct3. Any output not listed for a state is 0.
- RESET: entered while `rst_n` is low; all outputs 0; goes to FETCH on the first clock after release.
- FETCH: `mem_read`=1, `mem_size`=00.
  - `mem_ready`=0: stay.
  - `mem_ready`=1: `ir_write`=1 in the same cycle; go to DECODE.
- DECODE: latch `opcode` and `funct3`. Legal encodings:
  - 0110011 with funct3=000 (add)
  - 0010011 with funct3=111 (andi)
  - 1100011 with funct3=001 (bne)
  - 0100011 with funct3=001 (sh)
  - 0000011 with funct3=001 (lh)
  - Anything else: go to FAULT. Legal: go to EXEC.
- EXEC, per instruction:
  - add: `alu_control`=0000; go to WB.
  - andi: `alu_control`=0010, `alu_src_b`=1; go to WB.
  - bne: `alu_control`=1111, `pc_write`=1, `pc_src`=!`alu_zero`; go to FETCH (retire).
  - sh / lh: `alu_control`=0000, `alu_src_b`=1 (address calculation); go to MEM.
- MEM: `mem_size`=01, `alu_src_b`=1; `mem_write`=1 for sh, `mem_read`=1 for lh. The request is held until `mem_ready`=1, then:
  - sh: `pc_write`=1 in the same cycle; go to FETCH (retire).
  - lh: go to WB.
- WB: `reg_write`=1, `mem_to_reg`=1 for lh only, `pc_write`=1, `pc_src`=0; go to FETCH (retire).
- FAULT: `fault`=1, all other outputs 0. The state is left only by reset.
- Wait counter: width is clog2(MEM_TIMEOUT+1).
  - Cleared on every state entry.
  - Increments each FETCH/MEM cycle with `mem_ready`=0.
  - When it equals `MEM_TIMEOUT` with `mem_ready` still 0, the next state is FAULT.
  - If `mem_ready`=1 arrives in the same cycle as the limit, completion wins.

## Timing
- Zero-wait latency, FETCH to retire inclusive: bne 3 cycles, add/andi 4, sh 4, lh 5. Each memory wait cycle adds 1.
- One instruction is in flight at a time; there is no overlap.
- `rst_n` asserted mid-instruction: immediate asynchronous return to RESET. All outputs go to 0, counters to 0, `fault` to 0. No partial writes are issued after assertion.
- Reset value of every output is 0, including `retired`.

## Configuration
- `MCU_RETIRE_COUNT_EN` defined:
  - `retired` port exists.
  - It increments by 1 on every cycle with `pc_write`=1.
  - It wraps modulo 2^CNT_W and is frozen in FAULT.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `mcu_pkg`:
  - opcode constants
  - funct3 constants
  - ALU control codes
  - `mem_size` codes
  - state enum typedef
- Sub-module `mcu_decoder`: combinational. Maps {opcode, funct3} to an instruction class (ADD, ANDI, BNE, SH, LH) plus an `illegal` flag. Used in DECODE.

## Test plan
- Zero-wait add (opcode 0110011, funct3 000), `mem_ready` tied 1 → `ir_write` at cycle 1, `alu_control`=0000 at cycle 3, `reg_write`=`pc_write`=1 at cycle 4 with `pc_src`=0.
- bne with `alu_zero`=0, then bne with `alu_zero`=1 → `pc_write`=1 in EXEC with `pc_src`=1, then with `pc_src`=0; no `reg_write` in either case.
- lh with 3 `mem_ready`-low cycles in MEM → `mem_read`=1 and `mem_size`=01 held for 4 cycles, then WB with `reg_write`=`mem_to_reg`=1; retire at cycle 8.
- Illegal opcode 1111111, and andi with funct3=000 → FAULT after DECODE, `fault`=1 permanently, all enables 0 until `rst_n` pulses low.
- MEM_TIMEOUT=15 with `mem_ready` held 0 in FETCH → FAULT entered after exactly 16 FETCH cycles; a second run with `mem_ready`=1 on the 16th cycle completes normally.
- `rst_n` dropped during MEM of sh → `mem_write` falls in the same cycle, RESET then FETCH. With `MCU_RETIRE_COUNT_EN`: 5 retired instructions give `retired`=5, and it is 0 after reset.

Source files
------------

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared encodings for the multi-cycle control unit (opcodes, funct3,
// ALU control codes, memory size codes, FSM state and instruction class types).
package mcu_pkg;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ANDI = 7'b0010011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;
    localparam logic [6:0] OP_SH   = 7'b0100011;
    localparam logic [6:0] OP_LH   = 7'b0000011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_ANDI = 3'b111;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_LH   = 3'b001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_CMP = 4'b1111;

    localparam logic [1:0] MSZ_WORD = 2'b00;
    localparam logic [1:0] MSZ_HALF = 2'b01;

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_ADD, C_ANDI, C_BNE, C_SH, C_LH
    } instr_cls_t;
endpackage

// File: rtl/mcu_decoder.sv
// mcu_decoder: maps {opcode, funct3} to an instruction class plus an illegal flag.
module mcu_decoder
    import mcu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output instr_cls_t cls,
    output logic       illegal
);
    logic is_add, is_andi, is_bne, is_sh, is_lh;

    always_comb begin
        is_add  = opcode == OP_ADD  && funct3 == F3_ADD;
        is_andi = opcode == OP_ANDI && funct3 == F3_ANDI;
        is_bne  = opcode == OP_BNE  && funct3 == F3_BNE;
        is_sh   = opcode == OP_SH   && funct3 == F3_SH;
        is_lh   = opcode == OP_LH   && funct3 == F3_LH;
        cls     = is_andi ? C_ANDI : is_bne ? C_BNE : is_sh ? C_SH : is_lh ? C_LH : C_ADD;
        illegal = !(is_add || is_andi || is_bne || is_sh || is_lh);
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout
// and illegal-instruction fault; retired-instruction counter when MCU_RETIRE_COUNT_EN is defined.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_size,
    output logic                  alu_src_b,
    output logic                  mem_to_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
`ifdef MCU_RETIRE_COUNT_EN
    output logic [CNT_W-1:0]      retired,
`endif
    output logic                  fault
);
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state_q, state_d;
    instr_cls_t        cls_q, cls_d, dec_cls;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              dec_illegal, mem_phase, timeout;

    mcu_decoder u_dec (
        .opcode  (opcode),
        .funct3  (funct3),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign mem_phase = state_q == S_FETCH || state_q == S_MEM;
    // Completion beats the limit: timeout only fires while mem_ready is still low.
    assign timeout   = MEM_TIMEOUT != 0 && mem_phase && !mem_ready && wait_q == WAIT_W'(MEM_TIMEOUT);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_illegal ? S_FAULT : S_EXEC;
            end
            S_EXEC:   state_d = cls_q == C_BNE ? S_FETCH : (cls_q == C_SH || cls_q == C_LH) ? S_MEM : S_WB;
            S_MEM:    state_d = mem_ready ? (cls_q == C_SH ? S_FETCH : S_WB) : timeout ? S_FAULT : S_MEM;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FAULT;
        endcase
        wait_d = state_d != state_q ? '0 : (mem_phase && !mem_ready) ? wait_q + 1'b1 : wait_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cls_q   <= C_ADD;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    assign ir_write    = state_q == S_FETCH && mem_ready;
    assign mem_read    = state_q == S_FETCH || (state_q == S_MEM && cls_q == C_LH);
    assign mem_write   = state_q == S_MEM && cls_q == C_SH;
    assign mem_size    = state_q == S_MEM ? MSZ_HALF : MSZ_WORD;
    assign alu_src_b   = state_q == S_MEM || (state_q == S_EXEC && cls_q != C_ADD && cls_q != C_BNE);
    assign alu_control = ALU_CTRL_W'(state_q != S_EXEC ? ALU_ADD : cls_q == C_BNE ? ALU_CMP : cls_q == C_ANDI ? ALU_AND : ALU_ADD);
    assign pc_write    = (state_q == S_EXEC && cls_q == C_BNE) || (state_q == S_MEM && cls_q == C_SH && mem_ready) || state_q == S_WB;
    assign pc_src      = state_q == S_EXEC && cls_q == C_BNE && !alu_zero;
    assign reg_write   = state_q == S_WB;
    assign mem_to_reg  = state_q == S_WB && cls_q == C_LH;
    assign fault       = state_q == S_FAULT;

`ifdef MCU_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    assign retired_d = retired_q + CNT_W'(pc_write);
    assign retired   = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_q <= '0;
        else        retired_q <= retired_d;
    end
`endif
endmodule
